// File: rtl/scr1_dmi_arb.sv
// Two-requester DMI arbiter: r0 (TAP DMI) and r1 (system debug master) share one DM port through round-robin grant.
// Each requester has a one-entry request buffer. An access is aborted once it has run TIMEOUT_CYC cycles.
module scr1_dmi_arb #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req_i,
    input  logic              r0_wr_i,
    input  logic [ADDR_W-1:0] r0_addr_i,
    input  logic [DATA_W-1:0] r0_wdata_i,
    output logic              r0_resp_o,
    output logic              r0_err_o,
    output logic [DATA_W-1:0] r0_rdata_o,
    output logic              r0_busy_o,
    output logic              r0_ovf_o,
    input  logic              r0_ovf_clr_i,
    input  logic              r1_req_i,
    input  logic              r1_wr_i,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [DATA_W-1:0] r1_wdata_i,
    output logic              r1_resp_o,
    output logic              r1_err_o,
    output logic [DATA_W-1:0] r1_rdata_o,
    output logic              r1_busy_o,
    output logic              r1_ovf_o,
    input  logic              r1_ovf_clr_i,
    output logic              arb2dm_req_o,
    output logic              arb2dm_wr_o,
    output logic [ADDR_W-1:0] arb2dm_addr_o,
    output logic [DATA_W-1:0] arb2dm_wdata_o,
    input  logic              dm2arb_resp_i,
    input  logic [DATA_W-1:0] dm2arb_rdata_i
);
    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYC - 1);

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_q;
    logic [9:0] cnt_q, cnt_d;

    logic [1:0]             req, wr_in, clr;
    logic [1:0][ADDR_W-1:0] addr_in;
    logic [1:0][DATA_W-1:0] wdata_in;

    logic [1:0]             pend_q, wr_q, resp_q, err_q, ovf_q;
    logic [1:0][ADDR_W-1:0] addr_q;
    logic [1:0][DATA_W-1:0] wdata_q, rdata_q;

    logic       timeout, done;
    logic [1:0] cpl, free, load;

    assign req      = {r1_req_i, r0_req_i};
    assign wr_in    = {r1_wr_i, r0_wr_i};
    assign clr      = {r1_ovf_clr_i, r0_ovf_clr_i};
    assign addr_in  = {r1_addr_i, r0_addr_i};
    assign wdata_in = {r1_wdata_i, r0_wdata_i};

    assign timeout = (state_q == ACCESS) && !dm2arb_resp_i && (cnt_q == CNT_LAST);
    assign done    = (state_q == ACCESS) && (dm2arb_resp_i || timeout);

    // A buffer completing this cycle is free, so a new request lands instead of overrunning.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cpl[i]  = done && (grant_q == 1'(i));
            free[i] = !pend_q[i] || cpl[i];
            load[i] = req[i] && free[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            if (done) last_q <= grant_q;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    state_d = ACCESS;
                    grant_d = (&pend_q) ? ~last_q : pend_q[1];
                end
            end
            ACCESS: begin
                if (done) state_d = IDLE;
                else      cnt_d   = cnt_q + 10'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        arb2dm_req_o   = 1'b0;
        arb2dm_wr_o    = 1'b0;
        arb2dm_addr_o  = '0;
        arb2dm_wdata_o = '0;
        if (state_q == ACCESS) begin
            arb2dm_req_o   = 1'b1;
            arb2dm_wr_o    = wr_q[grant_q];
            arb2dm_addr_o  = addr_q[grant_q];
            arb2dm_wdata_o = wdata_q[grant_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= '0;
            wr_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            resp_q  <= '0;
            err_q   <= '0;
            ovf_q   <= '0;
            rdata_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                pend_q[i] <= load[i] || (pend_q[i] && !cpl[i]);
                resp_q[i] <= cpl[i];
                err_q[i]  <= cpl[i] && !dm2arb_resp_i;
                ovf_q[i]  <= (req[i] && !free[i]) || (ovf_q[i] && !clr[i]);
                if (load[i]) begin
                    wr_q[i]    <= wr_in[i];
                    addr_q[i]  <= addr_in[i];
                    wdata_q[i] <= wdata_in[i];
                end
                if (cpl[i] && dm2arb_resp_i && !wr_q[i]) rdata_q[i] <= dm2arb_rdata_i;
            end
        end
    end

    assign r0_resp_o  = resp_q[0];
    assign r0_err_o   = err_q[0];
    assign r0_rdata_o = rdata_q[0];
    assign r0_busy_o  = pend_q[0];
    assign r0_ovf_o   = ovf_q[0];
    assign r1_resp_o  = resp_q[1];
    assign r1_err_o   = err_q[1];
    assign r1_rdata_o = rdata_q[1];
    assign r1_busy_o  = pend_q[1];
    assign r1_ovf_o   = ovf_q[1];
endmodule

// File: tb/tb_scr1_dmi_arb.sv
// Directed bench for scr1_dmi_arb; completions are checked against a scoreboard of expected responses.
module tb_scr1_dmi_arb;
    localparam int AW = 7;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          r0_req, r0_wr, r0_resp, r0_err, r0_busy, r0_ovf, r0_ovf_clr;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rdata;
    logic          r1_req, r1_wr, r1_resp, r1_err, r1_busy, r1_ovf, r1_ovf_clr;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rdata;
    logic          arb_req, arb_wr, dm_resp;
    logic [AW-1:0] arb_addr;
    logic [DW-1:0] arb_wdata, dm_rdata;
    logic          dm_auto, dm_spur;

    typedef struct {
        int          id;
        logic        err;
        logic [31:0] rd;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] exp_rd[2];
    int          checks = 0;
    int          errors = 0;
    int          cycles;
    int          n;

    always #5 clk = ~clk;

    function automatic logic [31:0] dm_data(input logic [AW-1:0] a);
        return 32'hDEADBEEF ^ {25'd0, a} ^ 32'h11;
    endfunction

    // DM model: answers in the first ACCESS cycle when dm_auto is set
    assign dm_resp  = (dm_auto & arb_req) | dm_spur;
    assign dm_rdata = dm_data(arb_addr);

    scr1_dmi_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .r0_req_i(r0_req), .r0_wr_i(r0_wr), .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata),
        .r0_resp_o(r0_resp), .r0_err_o(r0_err), .r0_rdata_o(r0_rdata),
        .r0_busy_o(r0_busy), .r0_ovf_o(r0_ovf), .r0_ovf_clr_i(r0_ovf_clr),
        .r1_req_i(r1_req), .r1_wr_i(r1_wr), .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata),
        .r1_resp_o(r1_resp), .r1_err_o(r1_err), .r1_rdata_o(r1_rdata),
        .r1_busy_o(r1_busy), .r1_ovf_o(r1_ovf), .r1_ovf_clr_i(r1_ovf_clr),
        .arb2dm_req_o(arb_req), .arb2dm_wr_o(arb_wr), .arb2dm_addr_o(arb_addr),
        .arb2dm_wdata_o(arb_wdata), .dm2arb_resp_i(dm_resp), .dm2arb_rdata_i(dm_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic wr, input logic [AW-1:0] a, input logic err);
        exp_t e;
        if (!wr && !err) exp_rd[id] = dm_data(a);
        e.id  = id;
        e.err = err;
        e.rd  = exp_rd[id];
        sb.push_back(e);
    endtask

    task automatic sb_pop(input int id, input logic resp, input logic err, input logic [31:0] rd);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_unexpected_resp", {31'd0, resp}, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("sb_id", id, e.id);
            chk("sb_err", {31'd0, err}, {31'd0, e.err});
            chk("sb_rdata", rd, e.rd);
        end
    endtask

    task automatic wait_drain(input int maxc);
        int k = 0;
        while (sb.size() != 0 && k < maxc) begin
            step();
            k++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (r0_resp) sb_pop(0, r0_resp, r0_err, r0_rdata);
            if (r1_resp) sb_pop(1, r1_resp, r1_err, r1_rdata);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        r0_req = 0; r0_wr = 0; r0_addr = '0; r0_wdata = '0; r0_ovf_clr = 0;
        r1_req = 0; r1_wr = 0; r1_addr = '0; r1_wdata = '0; r1_ovf_clr = 0;
        dm_auto = 0; dm_spur = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        repeat (2) step();

        chk("rst_busy", {30'd0, r1_busy, r0_busy}, 32'd0);
        chk("rst_ovf", {30'd0, r1_ovf, r0_ovf}, 32'd0);
        chk("rst_resp_err", {28'd0, r1_resp, r0_resp, r1_err, r0_err}, 32'd0);
        chk("rst_rdata0", r0_rdata, 32'd0);
        chk("rst_rdata1", r1_rdata, 32'd0);
        chk("rst_arb", {30'd0, arb_req, arb_wr}, 32'd0);
        chk("rst_arb_addr", {25'd0, arb_addr}, 32'd0);
        chk("rst_arb_wdata", arb_wdata, 32'd0);
        rst = 0;
        step();

        // single read with immediate DM response: minimum latency
        dm_auto = 1;
        r0_req = 1; r0_wr = 0; r0_addr = 7'h11;
        push(0, 0, 7'h11, 0);
        step();
        r0_req = 0;
        chk("lat_busy", {31'd0, r0_busy}, 32'd1);
        chk("lat_t1_arb", {31'd0, arb_req}, 32'd0);
        step();
        chk("lat_t2_arb", {31'd0, arb_req}, 32'd1);
        chk("lat_t2_addr", {25'd0, arb_addr}, 32'h11);
        chk("lat_t2_wr", {31'd0, arb_wr}, 32'd0);
        step();
        chk("lat_t3_arb", {31'd0, arb_req}, 32'd0);
        chk("lat_t3_resp", {31'd0, r0_resp}, 32'd1);
        chk("lat_t3_rdata", r0_rdata, 32'hDEADBEEF);
        chk("lat_t3_err", {31'd0, r0_err}, 32'd0);
        chk("lat_t3_busy", {31'd0, r0_busy}, 32'd0);
        step();
        chk("lat_t4_resp", {31'd0, r0_resp}, 32'd0);

        // reset restores r0 tie priority
        rst = 1;
        step();
        rst = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        step();

        // simultaneous requests, three rounds of round-robin
        for (int k = 0; k < 3; k++) begin
            r0_req = 1; r0_wr = 0; r0_addr = 7'(48 + k);
            r1_req = 1; r1_wr = (k == 1); r1_addr = 7'(64 + k); r1_wdata = 32'hA000_0000 + k;
            push(0, 0, 7'(48 + k), 0);
            push(1, (k == 1), 7'(64 + k), 0);
            step();
            r0_req = 0; r1_req = 0; r1_wr = 0;
            if (k == 0) begin
                chk("rr_t1_arb", {31'd0, arb_req}, 32'd0);
                step();
                chk("rr_first_addr", {25'd0, arb_addr}, 32'h30);
                step();
                chk("rr_gap_arb", {31'd0, arb_req}, 32'd0);
                chk("rr_r0_resp", {31'd0, r0_resp}, 32'd1);
                chk("rr_r1_busy", {31'd0, r1_busy}, 32'd1);
                step();
                chk("rr_second_arb", {31'd0, arb_req}, 32'd1);
                chk("rr_second_addr", {25'd0, arb_addr}, 32'h40);
            end
            wait_drain(20);
        end

        // r1 write with no DM response times out after TO cycles
        dm_auto = 0;
        r1_req = 1; r1_wr = 1; r1_addr = 7'h10; r1_wdata = 32'h12345678;
        push(1, 1, 7'h10, 1);
        step();
        r1_req = 0; r1_wr = 0;
        step();
        chk("to_wr", {31'd0, arb_wr}, 32'd1);
        chk("to_addr", {25'd0, arb_addr}, 32'h10);
        chk("to_wdata", arb_wdata, 32'h12345678);
        cycles = 0;
        n = 0;
        while (arb_req && n < 40) begin
            cycles++;
            n++;
            step();
        end
        chk("to_len", cycles, TO);
        chk("to_resp", {31'd0, r1_resp}, 32'd1);
        chk("to_err", {31'd0, r1_err}, 32'd1);
        chk("to_r0_resp", {31'd0, r0_resp}, 32'd0);
        step();
        chk("to_resp_pulse", {31'd0, r1_resp}, 32'd0);

        // overrun, clear, set-wins and reload in the completion cycle
        r0_req = 1; r0_wr = 0; r0_addr = 7'h20;
        push(0, 0, 7'h20, 0);
        step();
        chk("ovf_busy", {31'd0, r0_busy}, 32'd1);
        r0_addr = 7'h55;
        step();
        r0_req = 0;
        chk("ovf_set", {31'd0, r0_ovf}, 32'd1);
        chk("ovf_buf_kept", {25'd0, arb_addr}, 32'h20);
        r0_req = 1; r0_ovf_clr = 1;
        step();
        r0_req = 0; r0_ovf_clr = 0;
        chk("ovf_set_wins", {31'd0, r0_ovf}, 32'd1);
        chk("ovf_r1_clean", {31'd0, r1_ovf}, 32'd0);
        step();
        chk("ovf_sticky", {31'd0, r0_ovf}, 32'd1);
        r0_ovf_clr = 1;
        step();
        r0_ovf_clr = 0;
        chk("ovf_clr", {31'd0, r0_ovf}, 32'd0);
        dm_auto = 1;
        r0_req = 1; r0_addr = 7'h21;
        push(0, 0, 7'h21, 0);
        step();
        r0_req = 0;
        chk("cpl_load_resp", {31'd0, r0_resp}, 32'd1);
        chk("cpl_load_ovf", {31'd0, r0_ovf}, 32'd0);
        chk("cpl_load_busy", {31'd0, r0_busy}, 32'd1);
        wait_drain(10);

        // reset during ACCESS with r1 pending
        dm_auto = 0;
        r0_req = 1; r0_addr = 7'h60; r1_req = 1; r1_addr = 7'h61;
        step();
        r0_req = 0; r1_req = 0;
        step();
        chk("rma_access", {31'd0, arb_req}, 32'd1);
        rst = 1;
        #1;
        chk("rma_async_arb", {31'd0, arb_req}, 32'd0);
        step();
        chk("rma_busy", {30'd0, r1_busy, r0_busy}, 32'd0);
        chk("rma_resp", {30'd0, r1_resp, r0_resp}, 32'd0);
        chk("rma_rdata", r0_rdata | r1_rdata, 32'd0);
        rst = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        step();
        dm_auto = 1;
        r0_req = 1; r0_addr = 7'h62;
        push(0, 0, 7'h62, 0);
        step();
        r0_req = 0;
        wait_drain(10);
        chk("rma_r1_lost", {31'd0, r1_busy}, 32'd0);

        // spurious DM response in IDLE
        dm_auto = 0;
        step();
        dm_spur = 1;
        step();
        dm_spur = 0;
        chk("spur_arb", {31'd0, arb_req}, 32'd0);
        chk("spur_rdata", r0_rdata, exp_rd[0]);
        step();
        chk("spur_resp", {30'd0, r1_resp, r0_resp}, 32'd0);
        chk("spur_busy", {30'd0, r1_busy, r0_busy}, 32'd0);

        repeat (3) step();
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
